// File: rtl/rand_sched.sv
// rand_sched: round-robin scheduler that serves each requester a bounded random value from a shared 9-bit LFSR.
// Optional build macro RAND_FREERUN_EN lets the LFSR advance on every clock instead of only while drawing.
module rand_sched #(
  parameter int unsigned NREQ        = 4,
  parameter logic [8:0]  SEED        = 9'd20,
  parameter int unsigned RETRY_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [9*NREQ-1:0]   req_max,
  output logic [NREQ-1:0]     grant,
  output logic [8:0]          rnd_out,
  output logic                rnd_valid,
  output logic                busy
);

  localparam int unsigned RW = 9;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef RAND_FREERUN_EN
  localparam bit FREERUN = 1'b1;
`else
  localparam bit FREERUN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [RW-1:0]   r_lf, w_lf_nx;
  logic [RW-1:0]   r_max, w_max_nx;
  logic [RW-1:0]   r_cand, w_cand_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [PW-1:0]   r_ptr, w_ptr_nx;
  logic [PW-1:0]   r_win, w_win_nx;
  logic [NREQ-1:0] r_grant, w_grant_nx;
  logic [RW-1:0]   r_rnd, w_rnd_nx;
  logic            r_valid, w_valid_nx;
  logic            r_busy, w_busy_nx;
  logic            w_found;
  logic [PW-1:0]   w_idx;
  logic [RW-1:0]   w_max;

  // One LFSR step; an all-zero result is replaced by the seed.
  function automatic logic [RW-1:0] lf_step(input logic [RW-1:0] v);
    logic [RW-1:0] n;
    n = {v[7:0], v[8] ^ v[4]};
    return (n == '0) ? SEED : n;
  endfunction

  // Round-robin pick: first set request at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  assign w_max = req_max[RW*32'(w_idx) +: RW];

  always_comb begin
    w_state_nx = r_state;
    w_lf_nx    = (FREERUN || r_state == S_DRAW) ? lf_step(r_lf) : r_lf;
    w_max_nx   = r_max;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_grant_nx = '0;
    w_rnd_nx   = '0;
    w_valid_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win_nx   = w_idx;
          w_max_nx   = w_max;
          w_cnt_nx   = '0;
          w_state_nx = S_DRAW;
        end
      end
      S_DRAW: begin
        w_cnt_nx   = r_cnt + CW'(1);
        w_state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (r_lf <= r_max) begin
          w_cand_nx  = r_lf;
          w_state_nx = S_DONE;
        end else if (32'(r_cnt) < RETRY_LIMIT) begin
          w_state_nx = S_DRAW;
        end else begin
          w_cand_nx  = r_max;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_grant_nx = NREQ'(1) << r_win;
        w_rnd_nx   = r_cand;
        w_valid_nx = 1'b1;
        w_ptr_nx   = (32'(r_win) == NREQ - 1) ? '0 : r_win + PW'(1);
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_lf    <= SEED;
      r_max   <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_rnd   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lf    <= w_lf_nx;
      r_max   <= w_max_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
      r_grant <= w_grant_nx;
      r_rnd   <= w_rnd_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign grant     = r_grant;
  assign rnd_out   = r_rnd;
  assign rnd_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rand_sched.sv
// Bench for rand_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rand_sched;

  localparam int unsigned NREQ  = 4;
  localparam logic [8:0]  SEED  = 9'd20;
  localparam int          RETRY = 4;
  localparam int          TMO   = 40;

  logic                CLK = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [9*NREQ-1:0]   req_max;
  logic [NREQ-1:0]     grant;
  logic [8:0]          rnd_out;
  logic                rnd_valid;
  logic                busy;

  int total = 0;
  int bad   = 0;

  logic [8:0] m_lf;
  int         m_ptr;

  rand_sched #(.NREQ(NREQ), .SEED(SEED), .RETRY_LIMIT(RETRY)) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_max(req_max),
    .grant(grant), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy)
  );

  initial forever #5 CLK = ~CLK;

  // Shift left by one within 9 bits, feed back bit8 xor bit4.
  function automatic logic [8:0] m_step(input logic [8:0] v);
    int n;
    n = ((int'(v) * 2) % 512) + (((int'(v) >> 8) ^ (int'(v) >> 4)) & 1);
    if (n == 0) n = int'(SEED);
    return 9'(n);
  endfunction

  function automatic logic [8:0] pick_max();
    case ($urandom_range(0, 3))
      0:       return 9'd0;
      1:       return 9'd511;
      2:       return 9'($urandom_range(0, 60));
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lf  = SEED;
    m_ptr = 0;
  endtask

  // Serve one transaction; the next rising edge must be the arbitration edge.
  task automatic serve(input string tag, input bit disturb);
    int win;
    int d;
    int cyc;
    logic [8:0] mx;
    logic [8:0] val;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (win < 0 && req[j]) win = j;
    end
    if (win < 0) begin
      check({tag, "_noreq"}, 32'(req), 32'd1);
      return;
    end
    mx  = req_max[9*win +: 9];
    val = mx;
    d   = RETRY;
    for (int n = 1; n <= RETRY; n++) begin
      m_lf = m_step(m_lf);
      if (m_lf <= mx) begin
        val = m_lf;
        d   = n;
        break;
      end
    end
    m_ptr = (win + 1) % NREQ;
    cyc = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (cyc == 1 && disturb) begin
        req[win] = 1'b0;
        for (int k = 0; k < NREQ; k++) req_max[9*k +: 9] = pick_max();
      end
      if (rnd_valid === 1'b1 || cyc >= TMO) break;
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    check({tag, "_strobe"}, 32'(rnd_valid), 32'd1);
    check({tag, "_grant"}, 32'(grant), 32'(1 << win));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef RAND_FREERUN_EN
    check({tag, "_le_max"}, 32'(rnd_out <= mx), 32'd1);
`else
    check({tag, "_latency"}, 32'(cyc - 1), 32'(1 + 2 * d));
    check({tag, "_value"}, 32'(rnd_out), 32'(val));
`endif
    req[win] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    req_max = '0;
    model_reset();
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rnd", 32'(rnd_out), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // First request right at reset release, then two more from requester 0.
    @(negedge CLK);
    reset = 1'b1;
    req = 4'b0001;
    req_max[8:0] = 9'd511;
    serve("first", 1'b0);
`ifndef RAND_FREERUN_EN
    check("first_41", 32'(rnd_out), 32'd41);
`endif
    @(negedge CLK);
    req = 4'b0001;
    req_max[8:0] = 9'd100;
    serve("second", 1'b0);
`ifndef RAND_FREERUN_EN
    check("second_82", 32'(rnd_out), 32'd82);
`endif
    @(negedge CLK);
    req = 4'b0001;
    req_max[8:0] = 9'd511;
    serve("third", 1'b0);
`ifndef RAND_FREERUN_EN
    check("third_165", 32'(rnd_out), 32'd165);
`endif

    // Every draw rejected: falls back to the bound.
    do_reset();
    req = 4'b0001;
    req_max[8:0] = 9'd30;
    serve("retry", 1'b0);
`ifndef RAND_FREERUN_EN
    check("retry_30", 32'(rnd_out), 32'd30);
`endif

    // Two requesters held: back-to-back service, 4 cycles apart.
    do_reset();
    req = 4'b0011;
    req_max[8:0]  = 9'd511;
    req_max[17:9] = 9'd511;
    serve("b2b_a", 1'b0);
    serve("b2b_b", 1'b0);

    // Abort in CHECK with reset.
    do_reset();
    req = 4'b0001;
    req_max[8:0] = 9'd30;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    reset = 1'b0;
    req   = '0;
    #1;
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_rnd", 32'(rnd_out), 32'd0);
    check("abort_valid", 32'(rnd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("abort_nostrobe", 32'(rnd_valid), 32'd0);
    end
    @(negedge CLK);
    reset = 1'b1;
    req = 4'b0001;
    req_max[8:0] = 9'd511;
    serve("after_abort", 1'b0);
`ifndef RAND_FREERUN_EN
    check("after_abort_41", 32'(rnd_out), 32'd41);
`endif

    // Randomized traffic with idle gaps, held requests and late disturbances.
    for (int it = 0; it < 60; it++) begin
      if (req == '0) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        @(negedge CLK);
        req = NREQ'($urandom_range(1, 15));
      end else if ($urandom_range(0, 1) == 1) begin
        req = req | NREQ'($urandom_range(0, 15));
      end
      for (int k = 0; k < NREQ; k++) req_max[9*k +: 9] = pick_max();
      serve("rand", $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
